// File: rtl/axis_dm_pkg.sv
// Shared DataMover command/status definitions for the S2MM and MM2S command generators.
package axis_dm_pkg;

    localparam int unsigned DM_CMD_W = 72;
    localparam int unsigned DM_BTT_W = 23;
    localparam int unsigned DM_STS_W = 8;
    localparam int unsigned OUTST_W  = 4;

    localparam int unsigned CMD_SOF_BIT  = 23;
    localparam int unsigned CMD_EOF_BIT  = 30;
    localparam int unsigned CMD_TYPE_BIT = 31;
    localparam int unsigned CMD_ADDR_LSB = 32;
    localparam int unsigned CMD_TAG_LSB  = 64;

    localparam int unsigned STS_OKAY_BIT   = 7;
    localparam int unsigned STS_SLVERR_BIT = 6;
    localparam int unsigned STS_DECERR_BIT = 5;
    localparam int unsigned STS_INTERR_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DRAIN    = 2'd3
    } dm_state_t;

    function automatic logic [DM_CMD_W-1:0] build_cmd(
        input logic [31:0]         addr,
        input logic [DM_BTT_W-1:0] btt,
        input logic                cmd_type,
        input logic [3:0]          tag
    );
        logic [DM_CMD_W-1:0] c;
        c                       = '0;
        c[DM_BTT_W-1:0]         = btt;
        c[CMD_SOF_BIT]          = 1'b1;
        c[CMD_EOF_BIT]          = 1'b1;
        c[CMD_TYPE_BIT]         = cmd_type;
        c[CMD_ADDR_LSB +: 32]   = addr;
        c[CMD_TAG_LSB +: 4]     = tag;
        return c;
    endfunction

    // flags = status bits [7:4] = {OKAY, SLVERR, DECERR, INTERR}
    function automatic logic sts_is_err(input logic [3:0] flags);
        return ~flags[STS_OKAY_BIT-4] | flags[STS_SLVERR_BIT-4]
             | flags[STS_DECERR_BIT-4] | flags[STS_INTERR_BIT-4];
    endfunction

endpackage

// File: rtl/axis_cmd_gen_mm2s_if.sv
// DataMover MM2S command and status streams between the generator (master) and DataMover (slave).
interface axis_cmd_gen_mm2s_if;
    import axis_dm_pkg::*;

    logic [DM_CMD_W-1:0] m_axis_cmd_tdata;
    logic                m_axis_cmd_tvalid;
    logic                m_axis_cmd_tready;
    logic [DM_STS_W-1:0] s_axis_sts_tdata;
    logic                s_axis_sts_tvalid;
    logic                s_axis_sts_tready;

    modport master (
        output m_axis_cmd_tdata, m_axis_cmd_tvalid,
        input  m_axis_cmd_tready,
        input  s_axis_sts_tdata, s_axis_sts_tvalid,
        output s_axis_sts_tready
    );

    modport slave (
        input  m_axis_cmd_tdata, m_axis_cmd_tvalid,
        output m_axis_cmd_tready,
        output s_axis_sts_tdata, s_axis_sts_tvalid,
        input  s_axis_sts_tready
    );

endinterface

// File: rtl/axis_cmd_gen_mm2s_sts_mon.sv
// dm_sts_mon: MM2S status handshake, outstanding-command counter and sticky error decode.
module dm_sts_mon
    import axis_dm_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_clr_all,
    input  logic                i_clr_err,
    input  logic                i_cmd_acc,
    input  logic [DM_STS_W-1:0] i_sts_tdata,
    input  logic                i_sts_tvalid,
    output logic                o_sts_tready,
    output logic [OUTST_W-1:0]  o_outstanding,
    output logic                o_err
);

    logic               r_sts_tready;
    logic [OUTST_W-1:0] r_outstanding;
    logic               r_err;
    logic               w_sts_acc;
    logic               w_underflow;
    logic               w_unused_tag;

    assign w_sts_acc    = i_sts_tvalid & r_sts_tready;
    assign w_underflow  = w_sts_acc & ~i_cmd_acc & (r_outstanding == '0);
    assign w_unused_tag = ^i_sts_tdata[3:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sts_tready  <= 1'b0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_sts_tready <= 1'b1;
            if (i_clr_all) begin
                r_outstanding <= '0;
                r_err         <= 1'b0;
            end else begin
                // Simultaneous accept and status cancel out; an orphan status is dropped.
                if (i_cmd_acc && !w_sts_acc)
                    r_outstanding <= r_outstanding + 1'b1;
                else if (w_sts_acc && !i_cmd_acc && !w_underflow)
                    r_outstanding <= r_outstanding - 1'b1;

                if (w_sts_acc && (sts_is_err(i_sts_tdata[7:4]) || w_underflow))
                    r_err <= 1'b1;
                else if (i_clr_err)
                    r_err <= 1'b0;
            end
        end
    end

    assign o_sts_tready  = r_sts_tready;
    assign o_outstanding = r_outstanding;
    assign o_err         = r_err;

endmodule

// File: rtl/axis_cmd_gen_mm2s.sv
// MM2S command generator: splits a playback region into DataMover read commands and tracks status.
// Optional continuous replay enabled by defining MM2S_LOOP_EN (adds the loop_en port).
module axis_cmd_gen_mm2s
    import axis_dm_pkg::*;
#(
    parameter int unsigned BTT_WIDTH       = 23,
    parameter int unsigned MAX_BURST_LEN   = 4096,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    axis_cmd_gen_mm2s_if.master        dm,
    input  logic                       read_start,
    input  logic                       read_reset,
    input  logic [31:0]                base_addr,
    input  logic [31:0]                play_size,
`ifdef MM2S_LOOP_EN
    input  logic                       loop_en,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam logic [31:0]        MAX_LEN = 32'(MAX_BURST_LEN);
    localparam logic [OUTST_W-1:0] MAX_OUT = OUTST_W'(MAX_OUTSTANDING);

    dm_state_t           r_state;
    logic [31:0]         r_addr;
    logic [31:0]         r_remaining;
    logic [3:0]          r_tag;
    logic [DM_CMD_W-1:0] r_cmd;
    logic                r_cmd_tvalid;
    logic                r_busy;
    logic                r_done;
`ifdef MM2S_LOOP_EN
    logic [31:0]         r_base;
    logic [31:0]         r_size;
`endif

    logic [31:0]          w_xfer;
    logic [BTT_WIDTH-1:0] w_btt;
    logic                 w_cmd_acc;
    logic                 w_last;
    logic                 w_start;
    logic [OUTST_W-1:0]   w_outstanding;
    logic                 w_err;
    logic                 w_sts_tready;

    assign w_xfer    = (r_remaining > MAX_LEN) ? MAX_LEN : r_remaining;
    assign w_btt     = w_xfer[BTT_WIDTH-1:0];
    assign w_cmd_acc = r_cmd_tvalid & dm.m_axis_cmd_tready;
    assign w_last    = (r_remaining <= w_xfer);
    assign w_start   = (r_state == ST_IDLE) & read_start & ~read_reset;

    dm_sts_mon u_sts_mon (
        .clk           (clk),
        .resetn        (resetn),
        .i_clr_all     (read_reset),
        .i_clr_err     (w_start),
        .i_cmd_acc     (w_cmd_acc),
        .i_sts_tdata   (dm.s_axis_sts_tdata),
        .i_sts_tvalid  (dm.s_axis_sts_tvalid),
        .o_sts_tready  (w_sts_tready),
        .o_outstanding (w_outstanding),
        .o_err         (w_err)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_tag        <= '0;
            r_cmd        <= '0;
            r_cmd_tvalid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef MM2S_LOOP_EN
            r_base       <= '0;
            r_size       <= '0;
`endif
        end else if (read_reset) begin
            r_state      <= ST_IDLE;
            r_cmd_tvalid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (read_start) begin
                        r_addr      <= base_addr;
                        r_remaining <= play_size;
                        r_tag       <= '0;
`ifdef MM2S_LOOP_EN
                        r_base      <= base_addr;
                        r_size      <= play_size;
`endif
                        if (play_size == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_outstanding < MAX_OUT) begin
                        r_cmd        <= build_cmd(r_addr, DM_BTT_W'(w_btt), 1'b0, r_tag);
                        r_cmd_tvalid <= 1'b1;
                        r_state      <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_cmd_acc) begin
                        r_cmd_tvalid <= 1'b0;
                        r_tag        <= r_tag + 1'b1;
                        r_addr       <= r_addr + w_xfer;
                        r_remaining  <= r_remaining - w_xfer;
                        if (w_last) begin
`ifdef MM2S_LOOP_EN
                            // Replay restarts straight from the latched region, skipping drain.
                            if (loop_en) begin
                                r_addr      <= r_base;
                                r_remaining <= r_size;
                                r_state     <= ST_ISSUE;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
`else
                            r_state <= ST_DRAIN;
`endif
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_outstanding == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dm.m_axis_cmd_tdata  = r_cmd;
    assign dm.m_axis_cmd_tvalid = r_cmd_tvalid;
    assign dm.s_axis_sts_tready = w_sts_tready;
    assign busy                 = r_busy;
    assign done                 = r_done;
    assign err                  = w_err;

endmodule

// File: tb/tb_axis_cmd_gen_mm2s.sv
// Scoreboard bench for axis_cmd_gen_mm2s: expected commands queued by stimulus, checked by a monitor.
module tb_axis_cmd_gen_mm2s;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        read_start = 1'b0;
    logic        read_reset = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] play_size = '0;
`ifdef MM2S_LOOP_EN
    logic        loop_en = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic        err;

    axis_cmd_gen_mm2s_if dm_if ();

    axis_cmd_gen_mm2s #(
        .BTT_WIDTH       (23),
        .MAX_BURST_LEN   (4096),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .dm         (dm_if.master),
        .read_start (read_start),
        .read_reset (read_reset),
        .base_addr  (base_addr),
        .play_size  (play_size),
`ifdef MM2S_LOOP_EN
        .loop_en    (loop_en),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cmd_cnt  = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    bit          auto_sts = 1'b0;
    logic [71:0] exp_q[$];
    int          sts_due[$];
    logic [7:0]  sts_dat[$];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] exp_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                            input logic [22:0] btt);
        return {4'h0, tag, addr, 9'b0_1_000000_1, btt};
    endfunction

    // Monitor: command handshakes against the scoreboard, done pulse width.
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && dm_if.m_axis_cmd_tvalid && dm_if.m_axis_cmd_tready) begin
                cmd_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_cmd: got %0h expected none", dm_if.m_axis_cmd_tdata);
                end else begin
                    chk("cmd_tdata", dm_if.m_axis_cmd_tdata, exp_q.pop_front());
                end
                if (auto_sts) begin
                    sts_due.push_back(cyc + 5);
                    sts_dat.push_back({4'h8, dm_if.m_axis_cmd_tdata[67:64]});
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_pulse_width", {71'd0, prev_done}, 72'd0);
            end
            prev_done = done;
        end
    end

    // Status responder: one queued status per cycle once its due cycle is reached.
    initial begin
        dm_if.s_axis_sts_tvalid = 1'b0;
        dm_if.s_axis_sts_tdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sts_due.size() > 0 && sts_due[0] <= cyc) begin
                void'(sts_due.pop_front());
                dm_if.s_axis_sts_tdata  = sts_dat.pop_front();
                dm_if.s_axis_sts_tvalid = 1'b1;
            end else begin
                dm_if.s_axis_sts_tvalid = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] size);
        base_addr  = base;
        play_size  = size;
        read_start = 1'b1;
        tick(1);
        read_start = 1'b0;
    endtask

    task automatic send_sts(input logic [7:0] d);
        sts_due.push_back(cyc);
        sts_dat.push_back(d);
    endtask

    task automatic wait_done(input int target, input int limit);
        int i;
        i = 0;
        while (done_cnt < target && i < limit) begin
            tick(1);
            i++;
        end
        chk("done_count", done_cnt, target);
        chk("busy_after_done", {71'd0, busy}, 72'd0);
    endtask

    task automatic wait_cmds(input int target, input int limit);
        int i;
        i = 0;
        while (cmd_cnt < target && i < limit) begin
            tick(1);
            i++;
        end
        chk("cmd_wait", cmd_cnt, target);
    endtask

    initial begin
        int b;
        int d;
        int i;
        dm_if.m_axis_cmd_tready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_tvalid",    {71'd0, dm_if.m_axis_cmd_tvalid}, 72'd0);
        chk("rst_tdata",     dm_if.m_axis_cmd_tdata, 72'd0);
        chk("rst_sts_tready", {71'd0, dm_if.s_axis_sts_tready}, 72'd0);
        chk("rst_busy",      {71'd0, busy}, 72'd0);
        chk("rst_done",      {71'd0, done}, 72'd0);
        chk("rst_err",       {71'd0, err}, 72'd0);
        @(posedge clk);
        #2 resetn = 1'b1;
        tick(1);
        chk("sts_tready_out_of_rst", {71'd0, dm_if.s_axis_sts_tready}, 72'd1);

        // Region of 10000 bytes: 4096 + 4096 + 1808
        dm_if.m_axis_cmd_tready = 1'b1;
        auto_sts = 1'b1;
        exp_q.push_back(exp_cmd(4'd0, 32'h1000_0000, 23'd4096));
        exp_q.push_back(exp_cmd(4'd1, 32'h1000_1000, 23'd4096));
        exp_q.push_back(exp_cmd(4'd2, 32'h1000_2000, 23'd1808));
        start(32'h1000_0000, 32'd10000);
        chk("busy_after_start", {71'd0, busy}, 72'd1);
        wait_done(1, 300);
        chk("split_cmds", cmd_cnt, 3);
        chk("split_sb_empty", exp_q.size(), 0);

        // Zero-size region: done next cycle, no command, never busy
        b = cmd_cnt;
        start(32'h3000_0000, 32'd0);
        chk("zero_done_pulse", {71'd0, done}, 72'd1);
        chk("zero_busy", {71'd0, busy}, 72'd0);
        tick(1);
        chk("zero_done_low", {71'd0, done}, 72'd0);
        tick(5);
        chk("zero_no_cmd", cmd_cnt - b, 0);
        chk("zero_done_count", done_cnt, 2);

        // Outstanding limit: 4 commands then stall until a status returns
        auto_sts = 1'b0;
        b = cmd_cnt;
        for (int k = 0; k < 8; k++)
            exp_q.push_back(exp_cmd(4'(k), 32'h1000_0000 + 32'(k) * 32'h1000, 23'd4096));
        start(32'h1000_0000, 32'd32768);
        tick(60);
        chk("stall_cmd_count", cmd_cnt - b, 4);
        chk("stall_busy", {71'd0, busy}, 72'd1);
        chk("stall_tvalid", {71'd0, dm_if.m_axis_cmd_tvalid}, 72'd0);
        send_sts(8'h80);
        tick(20);
        chk("fifth_cmd_after_sts", cmd_cnt - b, 5);
        auto_sts = 1'b1;
        send_sts(8'h81);
        send_sts(8'h82);
        send_sts(8'h83);
        send_sts(8'h84);
        wait_done(3, 400);
        chk("limit_sb_empty", exp_q.size(), 0);
        chk("limit_no_err", {71'd0, err}, 72'd0);

        // Back-pressure hold and error status
        auto_sts = 1'b0;
        dm_if.m_axis_cmd_tready = 1'b0;
        start(32'h2000_0000, 32'd4096);
        i = 0;
        while (!dm_if.m_axis_cmd_tvalid && i < 20) begin
            tick(1);
            i++;
        end
        chk("hold_tvalid_rise", {71'd0, dm_if.m_axis_cmd_tvalid}, 72'd1);
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("hold_tvalid", {71'd0, dm_if.m_axis_cmd_tvalid}, 72'd1);
            chk("hold_tdata", dm_if.m_axis_cmd_tdata, exp_cmd(4'd0, 32'h2000_0000, 23'd4096));
        end
        exp_q.push_back(exp_cmd(4'd0, 32'h2000_0000, 23'd4096));
        dm_if.m_axis_cmd_tready = 1'b1;
        tick(1);
        send_sts(8'h40);
        tick(3);
        chk("err_set", {71'd0, err}, 72'd1);
        wait_done(4, 50);
        tick(5);
        chk("err_sticky", {71'd0, err}, 72'd1);

        // read_reset after 2 of 8 commands
        b = cmd_cnt;
        exp_q.push_back(exp_cmd(4'd0, 32'h4000_0000, 23'd4096));
        exp_q.push_back(exp_cmd(4'd1, 32'h4000_1000, 23'd4096));
        start(32'h4000_0000, 32'd32768);
        chk("err_cleared_on_start", {71'd0, err}, 72'd0);
        wait_cmds(b + 2, 50);
        dm_if.m_axis_cmd_tready = 1'b0;
        tick(2);
        chk("abort_pending_tvalid", {71'd0, dm_if.m_axis_cmd_tvalid}, 72'd1);
        d = done_cnt;
        read_reset = 1'b1;
        tick(1);
        read_reset = 1'b0;
        chk("abort_tvalid", {71'd0, dm_if.m_axis_cmd_tvalid}, 72'd0);
        chk("abort_busy", {71'd0, busy}, 72'd0);
        tick(10);
        chk("abort_no_done", done_cnt, d);
        chk("abort_cmd_count", cmd_cnt - b, 2);
        dm_if.m_axis_cmd_tready = 1'b1;
        auto_sts = 1'b1;
        exp_q.push_back(exp_cmd(4'd0, 32'h4000_0000, 23'd4096));
        start(32'h4000_0000, 32'd4096);
        wait_done(d + 1, 100);

`ifdef MM2S_LOOP_EN
        // Continuous replay, then drop loop_en to finish the region
        b = cmd_cnt;
        d = done_cnt;
        loop_en = 1'b1;
        exp_q.push_back(exp_cmd(4'd0, 32'h5000_0000, 23'd4096));
        exp_q.push_back(exp_cmd(4'd1, 32'h5000_1000, 23'd4096));
        exp_q.push_back(exp_cmd(4'd2, 32'h5000_0000, 23'd4096));
        exp_q.push_back(exp_cmd(4'd3, 32'h5000_1000, 23'd4096));
        start(32'h5000_0000, 32'd8192);
        wait_cmds(b + 3, 100);
        chk("loop_no_done_yet", done_cnt, d);
        loop_en = 1'b0;
        wait_done(d + 1, 200);
        chk("loop_cmd_count", cmd_cnt - b, 4);
`endif

        tick(5);
        chk("final_sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
